// File: rtl/fpga2hps_pkg.sv
// Shared constants and address decode for the FPGA-to-HPS register bank.
// Optional TIMESTAMP register is enabled with `define FPGA2HPS_TIMESTAMP_EN.
package fpga2hps_pkg;

    // Register offsets above the channel shadow window
    localparam int STATUS_OFS     = 0;
    localparam int CTRL_OFS       = 1;
    localparam int SAMPLE_CNT_OFS = 2;
    localparam int TIMESTAMP_OFS  = 3;

    localparam int CTRL_FREEZE    = 0;
    localparam int CTRL_CLR_DROP  = 1;
    localparam int STATUS_DROP    = 16;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CHAN,
        SEL_STATUS,
        SEL_CTRL,
        SEL_SAMPLE_CNT,
        SEL_TIMESTAMP
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input int addr, input int num_ch);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr < num_ch)
            sel = SEL_CHAN;
        else if (addr == num_ch + STATUS_OFS)
            sel = SEL_STATUS;
        else if (addr == num_ch + CTRL_OFS)
            sel = SEL_CTRL;
        else if (addr == num_ch + SAMPLE_CNT_OFS)
            sel = SEL_SAMPLE_CNT;
`ifdef FPGA2HPS_TIMESTAMP_EN
        else if (addr == num_ch + TIMESTAMP_OFS)
            sel = SEL_TIMESTAMP;
`endif
        return sel;
    endfunction

endpackage

// File: rtl/fpga2hps_chan.sv
// One import channel: shadow register plus sticky "new data" flag.
module fpga2hps_chan
    import fpga2hps_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] q_import,
    input  logic              load,
    input  logic              rd_clr,
    output logic [DATA_W-1:0] shadow,
    output logic              new_data
);

    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              new_q, new_d;

    always_comb begin
        shadow_d = load ? q_import : shadow_q;
        // A load in the same cycle as the clearing read keeps the flag set
        new_d    = load | (new_q & ~rd_clr);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            new_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            new_q    <= new_d;
        end
    end

    assign shadow   = shadow_q;
    assign new_data = new_q;

endmodule

// File: rtl/fpga2hps_bank.sv
// Avalon-MM readable bank of FPGA-to-HPS channel shadows with STATUS/CTRL/SAMPLE_CNT.
// Define FPGA2HPS_TIMESTAMP_EN to add a free-running counter latched on freeze.
module fpga2hps_bank
    import fpga2hps_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     read,
    input  logic                     write,
    input  logic [DATA_W-1:0]        writedata,
    output logic [DATA_W-1:0]        readdata,
    output logic                     readdatavalid,
    input  logic [NUM_CH*DATA_W-1:0] Q_import,
    input  logic [NUM_CH-1:0]        Q_valid
);

    int        addr_int;
    reg_sel_e  sel;
    logic      rd_acc;
    logic      ctrl_wr;

    assign addr_int = int'(address);
    assign sel      = decode_addr(addr_int, NUM_CH);
    // A write wins over a simultaneous read; the read is dropped entirely
    assign rd_acc   = read & ~write;
    assign ctrl_wr  = write && (sel == SEL_CTRL);

    logic              freeze_q, freeze_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              rdvalid_q, rdvalid_d;

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] rd_clr;
    logic [NUM_CH-1:0] new_flag;
    logic [DATA_W-1:0] shadow [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign load[gi]   = Q_valid[gi] & ~freeze_q;
            assign rd_clr[gi] = rd_acc && (sel == SEL_CHAN) && (addr_int == gi);

            fpga2hps_chan #(
                .DATA_W(DATA_W)
            ) u_chan (
                .clock   (clock),
                .reset   (reset),
                .q_import(Q_import[gi*DATA_W +: DATA_W]),
                .load    (load[gi]),
                .rd_clr  (rd_clr[gi]),
                .shadow  (shadow[gi]),
                .new_data(new_flag[gi])
            );
        end
    endgenerate

    logic [DATA_W-1:0] status_val;
    logic [DATA_W-1:0] ctrl_val;

    assign status_val = DATA_W'(new_flag) | (DATA_W'(drop_q) << STATUS_DROP);
    assign ctrl_val   = DATA_W'(freeze_q);

`ifdef FPGA2HPS_TIMESTAMP_EN
    logic [DATA_W-1:0] ts_cnt_q, ts_cnt_d;
    logic [DATA_W-1:0] timestamp_q, timestamp_d;

    always_comb begin
        ts_cnt_d    = ts_cnt_q + {{(DATA_W-1){1'b0}}, 1'b1};
        timestamp_d = (freeze_d & ~freeze_q) ? ts_cnt_q : timestamp_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_cnt_q    <= '0;
            timestamp_q <= '0;
        end else begin
            ts_cnt_q    <= ts_cnt_d;
            timestamp_q <= timestamp_d;
        end
    end
`endif

    // Read mux sees register values from before this edge's updates
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_CHAN: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (addr_int == i)
                        rd_mux = shadow[i];
                end
            end
            SEL_STATUS:     rd_mux = status_val;
            SEL_CTRL:       rd_mux = ctrl_val;
            SEL_SAMPLE_CNT: rd_mux = sample_cnt_q;
`ifdef FPGA2HPS_TIMESTAMP_EN
            SEL_TIMESTAMP:  rd_mux = timestamp_q;
`endif
            default:        rd_mux = '0;
        endcase
    end

    always_comb begin
        freeze_d     = freeze_q;
        drop_d       = drop_q;
        sample_cnt_d = sample_cnt_q + {{(DATA_W-1){1'b0}}, |load};
        readdata_d   = rd_acc ? rd_mux : readdata_q;
        rdvalid_d    = rd_acc;

        if (ctrl_wr) begin
            freeze_d = writedata[CTRL_FREEZE];
            if (writedata[CTRL_CLR_DROP])
                drop_d = 1'b0;
        end
        if ((Q_valid & {NUM_CH{freeze_q}}) != '0)
            drop_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            freeze_q     <= 1'b0;
            drop_q       <= 1'b0;
            sample_cnt_q <= '0;
            readdata_q   <= '0;
            rdvalid_q    <= 1'b0;
        end else begin
            freeze_q     <= freeze_d;
            drop_q       <= drop_d;
            sample_cnt_q <= sample_cnt_d;
            readdata_q   <= readdata_d;
            rdvalid_q    <= rdvalid_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdvalid_q;

    logic unused_wdata;
    assign unused_wdata = ^writedata[DATA_W-1:2];

endmodule

// File: tb/tb_fpga2hps_bank.sv
// Scoreboard bench for fpga2hps_bank: a small register model pushes expected
// read data per issued read; each test pops and compares on readdatavalid.
module tb_fpga2hps_bank;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int AW = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic [AW-1:0]     address;
    logic              read;
    logic              write;
    logic [DW-1:0]     writedata;
    logic [DW-1:0]     readdata;
    logic              readdatavalid;
    logic [NC*DW-1:0]  Q_import;
    logic [NC-1:0]     Q_valid;

    fpga2hps_bank #(
        .DATA_W(DW),
        .NUM_CH(NC),
        .ADDR_W(AW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .Q_import     (Q_import),
        .Q_valid      (Q_valid)
    );

    always #5 clock = ~clock;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0]   exp_q[$];
    logic [31:0]   m_shadow[NC];
    logic [NC-1:0] m_new;
    logic          m_drop;
    logic          m_freeze;
    logic [31:0]   m_cnt;
    logic [31:0]   m_ts;
    logic [31:0]   cyc;

    // Free-running reference cycle count, restarted by reset like the timestamp counter
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [31:0] model_val(input int a);
        logic [31:0] v;
        v = 32'h0;
        if (a < NC)
            v = m_shadow[a];
        else if (a == NC) begin
            v[NC-1:0] = m_new;
            v[16]     = m_drop;
        end else if (a == NC + 1)
            v[0] = m_freeze;
        else if (a == NC + 2)
            v = m_cnt;
`ifdef FPGA2HPS_TIMESTAMP_EN
        else if (a == NC + 3)
            v = m_ts;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_shadow[i] = 32'h0;
        m_new = '0; m_drop = 1'b0; m_freeze = 1'b0; m_cnt = 32'h0; m_ts = 32'h0;
        exp_q.delete();
    endtask

    task automatic model_load(input logic [NC-1:0] mask);
        if (mask != '0) begin
            if (m_freeze) m_drop = 1'b1;
            else begin
                for (int i = 0; i < NC; i++) begin
                    if (mask[i]) begin
                        m_shadow[i] = Q_import[i*DW +: DW];
                        m_new[i]    = 1'b1;
                    end
                end
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        if (a == NC + 1) begin
            if (d[1]) m_drop = 1'b0;
            if (d[0] && !m_freeze) m_ts = cyc;
            m_freeze = d[0];
        end
    endtask

    task automatic issue_read(input int a);
        address = AW'(a);
        read    = 1'b1;
        exp_q.push_back(model_val(a));
        if (a < NC) m_new[a] = 1'b0;
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        address   = AW'(a);
        writedata = d;
        write     = 1'b1;
        model_write(a, d);
        @(negedge clock);
        write = 1'b0;
        $display("wr addr=%0d data=0x%08h", a, d);
    endtask

    task automatic pulse_valid(input logic [NC-1:0] mask, input logic [31:0] d);
        for (int i = 0; i < NC; i++)
            if (mask[i]) Q_import[i*DW +: DW] = d + i;
        Q_valid = mask;
        model_load(mask);
        @(negedge clock);
        Q_valid = '0;
    endtask

    task automatic test_reset();
        int addrs[$] = '{0, 1, 2, 3, NC, NC+1, NC+2, NC+3};
        logic [31:0] e;
        total_cnt++;
        if (readdatavalid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", readdatavalid);
        else pass_cnt++;
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL reset_data: got 0x%08h expected 0x00000000", readdata);
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clock);
        foreach (addrs[k]) begin
            issue_read(addrs[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", addrs[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL reset_read addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", addrs[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_load_read();
        int addrs[$] = '{NC, 2, NC, NC+2, 0};
        logic [31:0] e;
        pulse_valid(4'b0100, 32'h1234_5676);
        foreach (addrs[k]) begin
            issue_read(addrs[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", addrs[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL load_read addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", addrs[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_freeze();
        int a1[$] = '{NC+1, 0, NC, NC+2};
        int a2[$] = '{NC, NC+1};
        int a3[$] = '{3, NC, NC+2};
        logic [31:0] e;
        bus_write(NC+1, 32'h1);
        pulse_valid(4'b0001, 32'h0000_AAAA);
        foreach (a1[k]) begin
            issue_read(a1[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", a1[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL freeze_drop addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", a1[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
        bus_write(NC+1, 32'h2);
        foreach (a2[k]) begin
            issue_read(a2[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", a2[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL clr_drop addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", a2[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
        // Valid arriving in the same cycle as the freeze write still loads
        Q_import[3*DW +: DW] = 32'hCAFE_0003;
        Q_valid = 4'b1000;
        model_load(4'b1000);
        bus_write(NC+1, 32'h1);
        Q_valid = '0;
        foreach (a3[k]) begin
            issue_read(a3[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", a3[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL freeze_edge_load addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", a3[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
        bus_write(NC+1, 32'h0);
    endtask

    task automatic test_same_cycle();
        int addrs[$] = '{NC, 1, NC};
        logic [31:0] e;
        pulse_valid(4'b0010, 32'h0000_1110);
        Q_import[1*DW +: DW] = 32'h0000_2222;
        Q_valid = 4'b0010;
        issue_read(1);
        model_load(4'b0010);
        @(negedge clock);
        read = 1'b0; Q_valid = '0;
        e = exp_q.pop_front(); total_cnt++;
        $display("rd addr=1 valid=%0b data=0x%08h", readdatavalid, readdata);
        if (readdatavalid !== 1'b1 || readdata !== e)
            $display("FAIL same_cycle_old addr=1: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", readdatavalid, readdata, e);
        else pass_cnt++;
        foreach (addrs[k]) begin
            issue_read(addrs[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", addrs[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL same_cycle_sticky addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", addrs[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        int addrs[$] = '{NC+2, NC};
        logic [31:0] e;
        force dut.sample_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.sample_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        pulse_valid(4'b0001, 32'h0000_0005);
        issue_read(NC+2); @(negedge clock); read = 1'b0;
        e = exp_q.pop_front(); total_cnt++;
        $display("rd addr=%0d valid=%0b data=0x%08h", NC+2, readdatavalid, readdata);
        if (readdatavalid !== 1'b1 || readdata !== e)
            $display("FAIL cnt_wrap addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", NC+2, readdatavalid, readdata, e);
        else pass_cnt++;
        pulse_valid(4'b1111, 32'h0000_0010);
        foreach (addrs[k]) begin
            issue_read(addrs[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", addrs[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL cnt_after_wrap addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", addrs[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_unmapped();
        int addrs[$] = '{NC+3, NC+4, 31, NC+1, NC+2, NC};
        logic [31:0] e;
        bus_write(31, 32'hFFFF_FFFF);
        bus_write(NC+2, 32'h0000_0005);
        bus_write(NC, 32'hFFFF_FFFF);
        foreach (addrs[k]) begin
            issue_read(addrs[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", addrs[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL unmapped addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", addrs[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_collision();
        logic [31:0] e;
        address = AW'(NC+1); writedata = 32'h1; read = 1'b1; write = 1'b1;
        model_write(NC+1, 32'h1);
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        total_cnt++;
        $display("rw addr=%0d valid=%0b", NC+1, readdatavalid);
        if (readdatavalid !== 1'b0) $display("FAIL rw_collision_valid: got %0b expected 0", readdatavalid);
        else pass_cnt++;
        issue_read(NC+1); @(negedge clock); read = 1'b0;
        e = exp_q.pop_front(); total_cnt++;
        $display("rd addr=%0d valid=%0b data=0x%08h", NC+1, readdatavalid, readdata);
        if (readdatavalid !== 1'b1 || readdata !== e)
            $display("FAIL rw_collision_ctrl: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", readdatavalid, readdata, e);
        else pass_cnt++;
        bus_write(NC+1, 32'h0);
    endtask

    task automatic test_timestamp();
        logic [31:0] e;
        repeat (3) @(negedge clock);
        bus_write(NC+1, 32'h1);
        repeat (4) @(negedge clock);
        bus_write(NC+1, 32'h1);
        for (int r = 0; r < 2; r++) begin
            issue_read(NC+3); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", NC+3, readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL timestamp pass=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", r, readdatavalid, readdata, e);
            else pass_cnt++;
            bus_write(NC+1, 32'h0);
            repeat (2) @(negedge clock);
            bus_write(NC+1, 32'h1);
        end
        bus_write(NC+1, 32'h0);
    endtask

    task automatic test_back_to_back();
        int b[$] = '{0, 2, NC, NC+2, NC, 2};
        int z[$] = '{0, 1, 2, 3, NC, NC+1, NC+2, NC+3};
        logic [31:0] e;
        pulse_valid(4'b0101, 32'h0000_3000);
        issue_read(b[0]);
        for (int k = 0; k < b.size(); k++) begin
            @(negedge clock);
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", b[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL b2b addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", b[k], readdatavalid, readdata, e);
            else pass_cnt++;
            if (k + 1 < b.size()) issue_read(b[k+1]);
            else read = 1'b0;
        end
        // Reset lands just after the edge that accepted a read
        issue_read(2);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if (readdatavalid !== 1'b0 || readdata !== 32'h0)
            $display("FAIL reset_mid_read: got valid=%0b data=0x%08h, expected valid=0 data=0x00000000", readdatavalid, readdata);
        else pass_cnt++;
        read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        total_cnt++;
        if (readdatavalid !== 1'b0)
            $display("FAIL post_reset_valid: got %0b expected 0", readdatavalid);
        else pass_cnt++;
        foreach (z[k]) begin
            issue_read(z[k]); @(negedge clock); read = 1'b0;
            e = exp_q.pop_front(); total_cnt++;
            $display("rd addr=%0d valid=%0b data=0x%08h", z[k], readdatavalid, readdata);
            if (readdatavalid !== 1'b1 || readdata !== e)
                $display("FAIL post_reset_read addr=%0d: got valid=%0b data=0x%08h, expected valid=1 data=0x%08h", z[k], readdatavalid, readdata, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        Q_import  = '0;
        Q_valid   = '0;
        model_reset();
        repeat (2) @(negedge clock);
        test_reset();
        test_load_read();
        test_freeze();
        test_same_cycle();
        test_wrap();
        test_unmapped();
        test_collision();
        test_timestamp();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fpga2hps_bank.md
FPGA2HPS_BANK -- requirements
Module: fpga2hps_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of each import channel and of the Avalon data bus.
REQ-002 The block SHALL have parameter NUM_CH, default 4, range 1..16, meaning the number of import channels.
REQ-003 The block SHALL have parameter ADDR_W, default 5, meaning the Avalon word-address width; it must be at least clog2(NUM_CH+4).
REQ-004 clock  input  1  single clock for all logic; reset is asynchronous and active-high.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 address  input  ADDR_W  Avalon-MM word address.
REQ-007 read  input  1  Avalon read strobe.
REQ-008 write  input  1  Avalon write strobe.
REQ-009 writedata  input  DATA_W  Avalon write data.
REQ-010 readdata  output  DATA_W  registered read data.
REQ-011 readdatavalid  output  1  one-cycle pulse qualifying readdata.
REQ-012 Q_import  input  NUM_CH*DATA_W  flat channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-013 Q_valid  input  NUM_CH  per-channel update strobe.

Function
REQ-014 Address map SHALL be: 0..NUM_CH-1 channel shadows (RO); NUM_CH STATUS (RO); NUM_CH+1 CTRL (RW); NUM_CH+2 SAMPLE_CNT (RO); NUM_CH+3 TIMESTAMP (RO, macro only).
REQ-015 Shadow[i] SHALL load Q_import channel i on the clock edge where Q_valid[i]=1 and CTRL.freeze=0.
REQ-016 STATUS[i] SHALL be a sticky "new data" bit, set on a shadow load and cleared by a read of channel i; a set and a clear in the same cycle SHALL leave the bit set.
REQ-017 STATUS[16] SHALL be a sticky drop flag, set when Q_valid[i]=1 while freeze=1; it is cleared only by writing CTRL with bit 1 = 1.
REQ-018 CTRL bit 0 (freeze) SHALL be written from writedata[0]; a write of 1 takes effect on the following edge, so a Q_valid arriving in the write cycle still loads.
REQ-019 SAMPLE_CNT SHALL increment by 1 per cycle in which any shadow loads, wrapping modulo 2^DATA_W.
REQ-020 A read SHALL return data one cycle later (latency 1), with readdatavalid=1 for exactly that cycle; back-to-back reads SHALL be accepted every cycle.
REQ-021 Read data SHALL be the register value before any same-edge update.
REQ-022 Reads of unmapped addresses SHALL return 0 with readdatavalid=1; writes to them SHALL be ignored.
REQ-023 If read and write are asserted together, the write SHALL be performed and the read dropped (readdatavalid=0 next cycle).
REQ-024 Unused STATUS/CTRL bits SHALL read as 0.

Reset
REQ-025 On reset, readdata, readdatavalid, all shadows, STATUS, CTRL, SAMPLE_CNT and TIMESTAMP SHALL go to 0 immediately.
REQ-026 Reset asserted mid-read SHALL suppress the pending readdatavalid.

Configuration
REQ-027 With FPGA2HPS_TIMESTAMP_EN defined: a DATA_W free-running cycle counter SHALL exist; its value SHALL be latched into TIMESTAMP on each 0->1 freeze transition and SHALL be readable at NUM_CH+3.
REQ-028 Without FPGA2HPS_TIMESTAMP_EN: neither counter exists, and address NUM_CH+3 SHALL behave as unmapped.

Structure
REQ-029 Package fpga2hps_pkg SHALL hold the address-offset constants (STATUS, CTRL, SAMPLE_CNT, TIMESTAMP relative to NUM_CH), the CTRL bit indices (FREEZE=0, CLR_DROP=1) and the STATUS drop bit index (16).
REQ-030 Sub-module fpga2hps_chan SHALL implement one channel's shadow register and sticky bit; it is instantiated NUM_CH times with a generate loop.

Verification
REQ-031 Q_valid[2]=1 with ch2=0x1234_5678, then read addr 2 -> 0x1234_5678 one cycle later, STATUS bit2 1 before the read and 0 after.
REQ-032 Write CTRL=1, then Q_valid[0] with 0xAAAA -> shadow0 unchanged, STATUS[16]=1; write CTRL=2 -> STATUS[16]=0 and freeze=0.
REQ-033 Q_valid[1] in the same cycle as a read of addr 1 -> STATUS bit1 remains 1.
REQ-034 SAMPLE_CNT preset near 0xFFFF_FFFF through two loads -> wraps to 0x0000_0000, then 0x1.
REQ-035 Reads of addr NUM_CH+3 -> TIMESTAMP value latched at the freeze edge when the macro is defined, and 0 when it is not.
REQ-036 Reset asserted during back-to-back reads -> readdatavalid=0 and all registers read 0 after release.
